// File: rtl/mem_port_arbiter.sv
// Fetch / load-store arbiter for a single-port byte memory.
// Define MEM_PORT_ARBITER_FAIRNESS_EN to bound fetch starvation.
module mem_port_arbiter #(
    parameter int MEM_BYTES = 131072
`ifdef MEM_PORT_ARBITER_FAIRNESS_EN
    ,
    parameter int STARVE_LIMIT = 4
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    input  logic        d_sign_ex,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    logic        force_if;
    logic        if_bad;
    logic        d_bad;
    logic        d_mis;
    logic [31:0] size_mask;
    logic [3:0]  size_be;

`ifdef MEM_PORT_ARBITER_FAIRNESS_EN
    logic [2:0] starve_q;

    assign force_if = if_req && (starve_q == 3'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= 3'd0;
        end else if (if_gnt || !if_req) begin
            starve_q <= 3'd0;
        end else if (d_gnt) begin
            starve_q <= starve_q + 3'd1;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    assign d_gnt  = !rst && d_req && !force_if;
    assign if_gnt = !rst && if_req && !d_gnt;

    assign if_bad = if_addr >= 32'(MEM_BYTES);
    assign d_mis  = (d_size == 2'd1 && d_addr[0]) ||
                    (d_size == 2'd2 && d_addr[1:0] != 2'd0);
    assign d_bad  = (d_size == 2'd3) || d_mis ||
                    (d_addr >= 32'(MEM_BYTES));

    always_comb begin
        size_mask = 32'hFFFF_FFFF;
        size_be   = 4'hF;
        case (d_size)
            2'd0: begin
                size_mask = 32'h0000_00FF;
                size_be   = 4'h1;
            end
            2'd1: begin
                size_mask = 32'h0000_FFFF;
                size_be   = 4'h3;
            end
            default: ;
        endcase
    end

    // Memory outputs stay quiet unless an access is actually issued.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_be    = 4'd0;
        mem_wdata = 32'd0;
        if (d_gnt && !d_bad) begin
            mem_en   = 1'b1;
            mem_we   = d_we;
            mem_addr = {d_addr[31:2], 2'b00};
            mem_be   = d_we ? (size_be << d_addr[1:0]) : 4'hF;
            if (d_we) begin
                mem_wdata = (d_wdata & size_mask)
                            << {d_addr[1:0], 3'b000};
            end
        end else if (if_gnt && !if_bad) begin
            mem_en   = 1'b1;
            mem_addr = {if_addr[31:2], 2'b00};
            mem_be   = 4'hF;
        end
    end

    logic        if_rv_q;
    logic        if_err_q;
    logic [31:0] if_hold_q;
    logic        d_rv_q;
    logic        d_err_q;
    logic        d_store_q;
    logic        d_sign_q;
    logic [1:0]  d_size_q;
    logic [1:0]  d_off_q;
    logic [31:0] d_hold_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            if_rv_q   <= 1'b0;
            if_err_q  <= 1'b0;
            if_hold_q <= 32'd0;
            d_rv_q    <= 1'b0;
            d_err_q   <= 1'b0;
            d_store_q <= 1'b0;
            d_sign_q  <= 1'b0;
            d_size_q  <= 2'd0;
            d_off_q   <= 2'd0;
            d_hold_q  <= 32'd0;
        end else begin
            if_rv_q <= if_gnt;
            d_rv_q  <= d_gnt;
            if (if_gnt) begin
                if_err_q <= if_bad;
            end
            if (d_gnt) begin
                d_err_q   <= d_bad;
                d_store_q <= d_we;
                d_sign_q  <= d_sign_ex;
                d_size_q  <= d_size;
                d_off_q   <= d_addr[1:0];
            end
            if (if_rvalid) begin
                if_hold_q <= if_rdata;
            end
            if (d_rvalid) begin
                d_hold_q <= d_rdata;
            end
        end
    end

    logic [31:0] ld_sh;
    logic [31:0] ld_fmt;

    always_comb begin
        ld_sh  = mem_rdata >> {d_off_q, 3'b000};
        ld_fmt = ld_sh;
        case (d_size_q)
            2'd0: ld_fmt = {{24{d_sign_q & ld_sh[7]}}, ld_sh[7:0]};
            2'd1: ld_fmt = {{16{d_sign_q & ld_sh[15]}}, ld_sh[15:0]};
            default: ;
        endcase
    end

    // Gating with rst drops any response that was in flight.
    assign if_rvalid = if_rv_q && !rst;
    assign if_err    = if_rvalid && if_err_q;
    assign if_rdata  = rst ? 32'd0 :
                       if_rv_q ? (if_err_q ? 32'd0 : mem_rdata) :
                       if_hold_q;

    assign d_rvalid = d_rv_q && !rst;
    assign d_err    = d_rvalid && d_err_q;
    assign d_rdata  = rst ? 32'd0 :
                      d_rv_q ? ((d_err_q || d_store_q) ? 32'd0 : ld_fmt) :
                      d_hold_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cases plus random traffic
// checked against a byte-level memory reference.
module tb_mem_port_arbiter;

    localparam int MEM_BYTES    = 131072;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_size;
    logic        d_sign_ex;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    logic [7:0] ref_mem [MEM_BYTES];
    logic [7:0] dev_mem [MEM_BYTES];
    bit         loaded = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_size    (d_size),
        .d_sign_ex (d_sign_ex),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Memory device: copies the reference image once, then serves the DUT.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < MEM_BYTES; i++) dev_mem[i] <= ref_mem[i];
            loaded    <= 1'b1;
            mem_rdata <= 32'd0;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int k = 0; k < 4; k++)
                    if (mem_be[k])
                        dev_mem[int'(mem_addr[16:0]) + k]
                            <= mem_wdata[8*k +: 8];
            end else begin
                mem_rdata <= {dev_mem[int'(mem_addr[16:0]) + 3],
                              dev_mem[int'(mem_addr[16:0]) + 2],
                              dev_mem[int'(mem_addr[16:0]) + 1],
                              dev_mem[int'(mem_addr[16:0])]};
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] addr,
                                             input int n, input logic sx);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < n; i++)
            v = v | (32'(ref_mem[int'(addr) + i]) << (8 * i));
        if (sx && n < 4 && v[8*n-1])
            v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    function automatic void poke_word(input int a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) ref_mem[a + i] = w[8*i +: 8];
    endfunction

    task automatic idle_inputs();
        if_req    = 1'b0;
        if_addr   = 32'd0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = 32'd0;
        d_wdata   = 32'd0;
        d_size    = 2'd0;
        d_sign_ex = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        logic any;
        any = if_gnt | if_rvalid | (|if_rdata) | if_err | d_gnt |
              d_rvalid | (|d_rdata) | d_err | mem_en | mem_we |
              (|mem_addr) | (|mem_be) | (|mem_wdata);
        chk(tag, 32'(any), 32'd0);
    endtask

    task automatic do_data(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] size,
                           input logic sx);
        int          n;
        logic        bad;
        logic [3:0]  be;
        logic [31:0] wx;
        logic [31:0] rx;
        n   = 1 << size;
        bad = (size == 2'd3) || ((addr % 32'(n)) != 0) ||
              (addr >= 32'(MEM_BYTES));
        rx  = 32'd0;
        @(negedge clk);
        if_req    = 1'b0;
        d_req     = 1'b1;
        d_we      = we;
        d_addr    = addr;
        d_wdata   = wdata;
        d_size    = size;
        d_sign_ex = sx;
        #1;
        chk("d_gnt", 32'(d_gnt), 32'd1);
        chk("if_gnt_quiet", 32'(if_gnt), 32'd0);
        chk("d_mem_en", 32'(mem_en), 32'(!bad));
        if (!bad) begin
            chk("d_mem_addr", mem_addr, addr & ~32'd3);
            chk("d_mem_we", 32'(mem_we), 32'(we));
            if (we) begin
                be = 4'd0;
                wx = 32'd0;
                for (int i = 0; i < n; i++) begin
                    be[addr % 4 + i] = 1'b1;
                    wx[8*(addr % 4 + i) +: 8] = wdata[8*i +: 8];
                    ref_mem[int'(addr) + i] = wdata[8*i +: 8];
                end
                chk("st_mem_be", 32'(mem_be), 32'(be));
                chk("st_mem_wdata", mem_wdata, wx);
            end else begin
                chk("ld_mem_be", 32'(mem_be), 32'hF);
                rx = ref_load(addr, n, sx);
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        chk("d_rvalid", 32'(d_rvalid), 32'd1);
        chk("if_rvalid_quiet", 32'(if_rvalid), 32'd0);
        chk("d_err", 32'(d_err), 32'(bad));
        chk("d_rdata", d_rdata, rx);
    endtask

    task automatic do_fetch(input logic [31:0] addr);
        logic        bad;
        logic [31:0] rx;
        bad = addr >= 32'(MEM_BYTES);
        rx  = bad ? 32'd0 : ref_load(addr & ~32'd3, 4, 1'b0);
        @(negedge clk);
        d_req   = 1'b0;
        if_req  = 1'b1;
        if_addr = addr;
        #1;
        chk("if_gnt", 32'(if_gnt), 32'd1);
        chk("d_gnt_quiet", 32'(d_gnt), 32'd0);
        chk("if_mem_en", 32'(mem_en), 32'(!bad));
        if (!bad) begin
            chk("if_mem_addr", mem_addr, addr & ~32'd3);
            chk("if_mem_we", 32'(mem_we), 32'd0);
            chk("if_mem_be", 32'(mem_be), 32'hF);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        chk("if_rvalid", 32'(if_rvalid), 32'd1);
        chk("d_rvalid_quiet", 32'(d_rvalid), 32'd0);
        chk("if_err", 32'(if_err), 32'(bad));
        chk("if_rdata", if_rdata, rx);
    endtask

    initial begin
        logic [31:0] held;
        int          exp_if;
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'($urandom);
        poke_word(32'h100, 32'h0050_0513);
        poke_word(32'h200, 32'h80FF_1234);
        rst = 1'b1;
        idle_inputs();

        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset_state");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all_zero("after_release");

        do_fetch(32'h100);
        do_data(1'b0, 32'h203, 32'd0, 2'd0, 1'b1);
        do_data(1'b0, 32'h203, 32'd0, 2'd0, 1'b0);
        do_data(1'b1, 32'h402, 32'hABCD_1234, 2'd1, 1'b0);
        do_data(1'b0, 32'h400, 32'd0, 2'd2, 1'b0);
        held = ref_load(32'h400, 4, 1'b0);
        @(negedge clk);
        #1;
        chk("hold_rvalid", 32'(d_rvalid), 32'd0);
        chk("hold_rdata", d_rdata, held);
        chk("hold_err", 32'(d_err), 32'd0);
        do_data(1'b0, 32'h401, 32'd0, 2'd2, 1'b0);
        do_data(1'b0, 32'h2_0001, 32'd0, 2'd1, 1'b0);
        do_data(1'b0, 32'h2_0000, 32'd0, 2'd0, 1'b0);
        do_data(1'b0, 32'h1_FFFF, 32'd0, 2'd0, 1'b1);
        do_data(1'b1, 32'h10, 32'h1234_5678, 2'd3, 1'b0);
        do_fetch(32'h2_0000);
        do_fetch(32'h1_FFFF);

        // Contention: both requesters held for six cycles.
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if_req    = 1'b1;
            if_addr   = 32'h100;
            d_req     = 1'b1;
            d_we      = 1'b0;
            d_addr    = 32'h200;
            d_size    = 2'd2;
            #1;
            exp_if = 0;
`ifdef MEM_PORT_ARBITER_FAIRNESS_EN
            exp_if = (c % (STARVE_LIMIT + 1) == 0) ? 1 : 0;
`endif
            chk($sformatf("contend_if_gnt_c%0d", c), 32'(if_gnt),
                32'(exp_if));
            chk($sformatf("contend_d_gnt_c%0d", c), 32'(d_gnt),
                32'(1 - exp_if));
        end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);

        // Reset the cycle after a load grant drops its response.
        @(negedge clk);
        d_req  = 1'b1;
        d_addr = 32'h200;
        d_size = 2'd2;
        #1;
        chk("rst_pre_gnt", 32'(d_gnt), 32'd1);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("rst_drop_rvalid", 32'(d_rvalid), 32'd0);
        chk_all_zero("rst_cycle_zero");
        @(negedge clk);
        d_req  = 1'b1;
        if_req = 1'b1;
        #1;
        chk_all_zero("rst_req_blocked");
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        #1;
        chk_all_zero("rst_release_zero");

        for (int t = 0; t < 300; t++) begin
            int          r;
            int          sel;
            logic [1:0]  sz;
            logic [31:0] a;
            sel = $urandom_range(0, 3);
            sz  = 2'($urandom_range(0, 3));
            r   = $urandom_range(0, 9);
            if (r == 0) a = $urandom | 32'h0002_0000;
            else a = 32'($urandom_range(0, MEM_BYTES - 1));
            if (sel == 0) begin
                do_fetch(a);
            end else begin
                if (r < 7 && sz != 2'd3)
                    a = a & ~((32'd1 << sz) - 32'd1);
                do_data(1'($urandom), a, $urandom, sz, 1'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port, little-endian byte memory (128 KiB) between the instruction-fetch requester and the load/store requester.
- Arbitrates requests each cycle and issues at most one word-aligned memory access per cycle.
- Formats byte/half/word loads (lane shift, mask, sign extension) and byte-enabled stores.
- Returns responses exactly one cycle after grant. Sits between the core pipeline and the memory array.

Parameters:
- MEM_BYTES, 131072, memory size in bytes; any byte address >= MEM_BYTES is out of range.
- STARVE_LIMIT, 4, consecutive data grants while fetch waits before fetch is forced (fairness feature only).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- if_req  in  1  fetch request; held with if_addr stable until if_gnt.
- if_addr  in  32  fetch byte address; bits [1:0] ignored.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  fetch response valid.
- if_rdata  out  32  fetched word.
- if_err  out  1  fetch out of range; qualified by if_rvalid.
- d_req  in  1  data request; held with all d_* inputs stable until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data in bits [7:0], [15:0] or [31:0] according to size.
- d_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- d_sign_ex  in  1  sign-extend the load result.
- d_gnt  out  1  data accepted this cycle.
- d_rvalid  out  1  data response valid (loads and stores).
- d_rdata  out  32  formatted load data; 0 for stores and errors.
- d_err  out  1  misaligned, out of range or illegal size; qualified by d_rvalid.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  write strobe.
- mem_addr  out  32  word address, bits [1:0] = 0.
- mem_be  out  4  byte enables; bit k = byte addr+k.
- mem_wdata  out  32  lane-aligned write data.
- mem_rdata  in  32  read word; valid the cycle after a read issue.

Behaviour:
- Reset:
  - Synchronous reset on rst: all registered outputs 0; owner register cleared; starve counter 0.
  - While rst = 1, if_gnt, d_gnt and mem_en are forced 0.
  - A response in flight when rst asserts is dropped (no rvalid after reset).
- Arbitration (combinational, same cycle):
  - Data has fixed priority: if d_req then d_gnt = 1; otherwise if if_req then if_gnt = 1.
  - At most one gnt per cycle.
  - Back-to-back grants are allowed every cycle with no bubble.
- Issue:
  - A granted legal access drives mem_en = 1 in the grant cycle.
  - mem_addr = {addr[31:2], 2'b00}.
  - Fetch: mem_we = 0, mem_be = 4'hF.
  - Data store: mem_we = 1, mem_be = size mask << addr[1:0] (byte 4'b0001, half 4'b0011, word 4'b1111).
  - Store write data: mem_wdata = (d_wdata & size mask) << 8*addr[1:0].
- Errors:
  - Misaligned: half with addr[0] = 1; word with addr[1:0] != 0.
  - Out of range: addr >= MEM_BYTES.
  - Illegal: d_size = 3.
  - A granted erroneous request still receives gnt but drives mem_en = 0; the response carries err = 1 and rdata = 0.
- Response:
  - Registered owner/size/offset/sign/err state.
  - Exactly 1 cycle after gnt, the owner's rvalid = 1 for one cycle.
  - Fetch response: if_rdata = mem_rdata.
  - Load response: shift mem_rdata right by 8*offset, mask to size, then if d_sign_ex replicate bit 7 or 15 into the upper bits.
  - Store response: rvalid with rdata = 0.
  - rdata is held until the next response; err is cleared when rvalid = 0.
- Simultaneous requests:
  - Both req in the same cycle: data granted, fetch stalls (if_gnt = 0) and keeps its request.
  - A response and a new grant in the same cycle are independent.

Optional Feature:
- MEM_PORT_ARBITER_FAIRNESS_EN defined:
  - A 3-bit starve counter increments on each d_gnt while if_req = 1 and fetch is not granted.
  - When the counter equals STARVE_LIMIT, fetch wins the next contested cycle.
  - The counter resets to 0 on if_gnt or when if_req = 0.
- Undefined: pure data priority; fetch can starve indefinitely.

Test Plan:
- Fetch only, if_addr = 0x100 with mem word 0x00500513 at 0x100 -> if_gnt the same cycle, mem_en = 1, mem_addr = 0x100; next cycle if_rvalid = 1, if_rdata = 0x00500513.
- Byte load at 0x203, word there 0x80FF1234, sign_ex = 1 -> mem_be = 4'hF; d_rdata = 0xFFFFFF80. Same access with sign_ex = 0 -> 0x00000080.
- Half store 0xABCD1234 to 0x402 -> mem_we = 1, mem_be = 4'b1100, mem_wdata = 0x12340000; next cycle d_rvalid = 1, d_rdata = 0, d_err = 0.
- Word load at 0x401, then half at 0x20001 -> each: d_gnt = 1, mem_en = 0; next cycle d_rvalid = 1, d_err = 1, d_rdata = 0.
- Fetch and data requests held for 6 cycles:
  - Without the macro: 6 d_gnt, 0 if_gnt.
  - With MEM_PORT_ARBITER_FAIRNESS_EN: if_gnt in cycle 5, data resumes in cycle 6.
- rst asserted the cycle after a load grant -> no d_rvalid; all outputs 0 during reset and the cycle after release.
